// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between execute and word-addressed data memory.
// Optional LSU_BOUNDS_CHECK_EN flags addresses >= DEPTH as errors.
module lsu_mem_ctrl #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [DATA_W-1:0] req_base,
  input  logic [DATA_W-1:0] req_offset,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [4:0]        resp_rd,
  output logic              resp_is_load,
  output logic              resp_err,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [CW-1:0]     cnt;
  logic              store_q;
  logic [DATA_W-1:0] addr;
  logic              accept;
  logic              oob;

  assign addr       = req_base + req_offset;
  assign req_ready  = (state == IDLE) && !rst;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == RESP);

`ifdef LSU_BOUNDS_CHECK_EN
  assign oob = (addr >= DATA_W'(DEPTH));
`else
  assign oob = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_d = oob ? RESP : SETUP;
        end
      end
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (cnt == '0) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes follow next state so they drop on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      store_q      <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      resp_rdata   <= '0;
      resp_rd      <= '0;
      resp_is_load <= 1'b0;
      resp_err     <= 1'b0;
    end else begin
      mem_read  <= (state_d == ACCESS) && !store_q;
      mem_write <= (state_d == ACCESS) && store_q;
      if (accept) begin
        mem_addr     <= addr;
        mem_wdata    <= req_wdata;
        store_q      <= req_is_store;
        resp_rd      <= req_rd;
        resp_is_load <= !req_is_store;
        resp_err     <= oob;
        resp_rdata   <= '0;
      end
      if (state == SETUP) begin
        cnt <= CW'(WAIT_CYCLES - 1);
      end else if (state == ACCESS && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (state == ACCESS && cnt == '0) begin
        resp_rdata <= store_q ? '0 : mem_rdata;
      end
      if (state == RESP && resp_ready) begin
        resp_err <= 1'b0;
      end
    end
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator sitting between the execute stage and the word-addressed data memory; the memory is the responder.
- Accepts one load or store request per transaction over a valid/ready handshake and computes the effective address as base + offset.
- Drives the memory's address, read strobe, write strobe and write data, then returns load data or a store acknowledgement over a second valid/ready handshake.
- Keeps address and data stable around the memory's level-sensitive strobes.

Parameters:
- DATA_W, 32, data and address word width.
- DEPTH, 256, number of memory words; legal addresses 0..DEPTH-1.
- WAIT_CYCLES, 1, cycles the read/write strobe stays asserted (>=1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request offered.
- req_ready  out  1  controller can accept a request.
- req_is_store  in  1  1 = store, 0 = load.
- req_base  in  DATA_W  base register value.
- req_offset  in  DATA_W  offset, already sign-extended.
- req_wdata  in  DATA_W  store data.
- req_rd  in  5  destination register tag for loads.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  DATA_W  load data; 0 for stores.
- resp_rd  out  5  echoed req_rd.
- resp_is_load  out  1  1 if the response is for a load.
- resp_err  out  1  out-of-range access; see Optional Feature.
- mem_addr  out  DATA_W  memory address.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (synchronous, rst high at a rising edge):
  - State goes to IDLE.
  - resp_valid, mem_read, mem_write, resp_err, resp_is_load = 0.
  - resp_rdata, resp_rd, mem_addr, mem_wdata = 0.
  - Wait counter cleared.
  - req_ready = 0 while rst is high.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready = 1; req_ready is a combinational decode of state == IDLE and !rst.
  - When req_valid && req_ready: register addr = (req_base + req_offset) mod 2^DATA_W, plus wdata, type and rd, then go to SETUP.
- SETUP (1 cycle):
  - mem_addr and mem_wdata present the registered values.
  - Both strobes stay low so the address settles before the level-sensitive memory sees a strobe.
  - Next state is ACCESS; counter loads WAIT_CYCLES-1.
- ACCESS (WAIT_CYCLES cycles):
  - Exactly one strobe is high: mem_write for a store, mem_read for a load. mem_read and mem_write are never high together.
  - Counter decrements each cycle.
  - When the counter reaches 0: for a load, capture mem_rdata into resp_rdata; for a store, set resp_rdata = 0. Then go to RESP.
- Strobe registration: strobes are registered and drop on the same edge that enters RESP.
- Address/data hold: mem_addr and mem_wdata hold their value from SETUP through the entire RESP state. They change only when a new request is accepted, so no address change ever coincides with a strobe.
- RESP:
  - resp_valid = 1; resp_rdata, resp_rd, resp_is_load and resp_err are held stable.
  - On resp_valid && resp_ready, go to IDLE.
  - Back-pressure has no timeout.
- Latency: resp_valid rises WAIT_CYCLES+2 cycles after the accepting edge.
- Throughput: one transaction per WAIT_CYCLES+3 cycles minimum, since req_ready is low from SETUP through RESP. A new request is accepted no earlier than the cycle after the response handshake.
- Address arithmetic: 32-bit add with wrap and no overflow flag. A negative offset is valid, e.g. base 8 + offset 0xFFFFFFFC gives 4.
- Reset mid-operation: aborts immediately, strobes deasserted at that edge, no response issued. A store whose strobe was already high may have been written; this is accepted behaviour.

Optional Feature:
- Macro: LSU_BOUNDS_CHECK_EN.
- Defined:
  - In IDLE, an accepted request with addr >= DEPTH skips SETUP and ACCESS and goes directly to RESP.
  - No strobe is asserted; resp_err = 1 and resp_rdata = 0.
  - resp_err is cleared when the response handshake completes.
- Undefined:
  - No range check; the full address is driven on mem_addr and the memory truncates it.
  - resp_err is tied to 0.

Test Plan:
- Store then load, WAIT_CYCLES=1: store base 0, offset 4, data 0xDEADBEEF; then load base 4, offset 0, rd 7 -> load response has resp_rdata 0xDEADBEEF, resp_rd 7. resp_valid rises 3 cycles after each accept. mem_write pulses exactly 1 cycle, with mem_addr = 4 stable one cycle before and after the pulse.
- Preloaded read: load base 2, offset 2 with mem word 4 = 10 -> resp_rdata 10, resp_is_load 1, resp_err 0.
- Back-pressure: hold resp_ready = 0 for 5 cycles -> resp_valid and data stable, req_ready stays 0, a pending req_valid is not accepted until one cycle after the handshake.
- Negative offset: base 8, offset 0xFFFFFFFC, store 0x55 -> mem_addr 4. A subsequent load of word 4 returns 0x55.
- Reset during ACCESS with WAIT_CYCLES=3, rst pulsed in the 2nd ACCESS cycle -> strobes low at that edge, no resp_valid, req_ready 1 one cycle after rst falls.
- Bounds check with LSU_BOUNDS_CHECK_EN defined: load at addr 300 -> no mem_read pulse, resp_err 1, resp_rdata 0, response 1 cycle after accept. With the macro undefined -> mem_addr 300, mem_read pulses, resp_err 0.
